axi_lite_mmu_regfile: RTL

//  Parametrised AXI4-Lite slave register file; successor to the fixed MMU/cosim register slave.

---
 rtl/axi_lite_mmu_regfile_if.sv | 34 +++
 rtl/axi_lite_mmu_regfile.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_mmu_regfile_if.sv
// AXI4-Lite bus bundle for the MMU/cosim register file.
// The master drives addresses, data, valids and response readies; the slave answers.
interface axi_lite_mmu_regfile_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_lite_mmu_regfile.sv
// Parametrised AXI4-Lite register file: NUM_REGS read/write control registers
// followed by NUM_RO read-only status words. Write and read channels run
// independently; every output is driven from flops only.
module axi_lite_mmu_regfile #(
  parameter int                         DATA_W    = 64,
  parameter int                         ADDR_W    = 64,
  parameter int                         NUM_REGS  = 8,
  parameter int                         NUM_RO    = 2,
  parameter logic [ADDR_W-1:0]          BASE_ADDR = {ADDR_W{1'b0}},
  parameter logic [NUM_REGS*DATA_W-1:0] RW_RESET  = {(NUM_REGS*DATA_W){1'b0}},
  localparam int                        RO_N      = (NUM_RO > 0) ? NUM_RO : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  axi_lite_mmu_regfile_if.slave        s,
  input  logic [RO_N*DATA_W-1:0]       ro_status,
  output logic [NUM_REGS*DATA_W-1:0]   regs_q,
  output logic [NUM_REGS-1:0]          reg_wpulse
);
  localparam int NB  = DATA_W / 8;
  localparam int LSB = $clog2(NB);

  typedef enum logic [0:0] {W_IDLE = 1'b0, W_RESP = 1'b1} w_state_t;
  typedef enum logic [0:0] {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

  // Word index relative to the base; meaningless when the address is below the base.
  function automatic logic [ADDR_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
    return (a - BASE_ADDR) >> LSB;
  endfunction

  // Borrow out of (a - BASE_ADDR) flags an address below the window.
  function automatic logic below_base(input logic [ADDR_W-1:0] a);
    logic [ADDR_W:0] diff;
    diff = {1'b0, a} - {1'b0, BASE_ADDR};
    return diff[ADDR_W];
  endfunction

  function automatic logic is_rw(input logic [ADDR_W-1:0] a);
    return !below_base(a) && (addr_idx(a) < ADDR_W'(NUM_REGS));
  endfunction

  function automatic logic is_ro(input logic [ADDR_W-1:0] a);
    return !below_base(a) && (addr_idx(a) >= ADDR_W'(NUM_REGS)) &&
           (addr_idx(a) < ADDR_W'(NUM_REGS + NUM_RO));
  endfunction

  function automatic logic [DATA_W-1:0] sel_rw(input logic [ADDR_W-1:0] idx,
                                               input logic [NUM_REGS*DATA_W-1:0] regs);
    logic [DATA_W-1:0] v;
    v = {DATA_W{1'b0}};
    for (int i = 0; i < NUM_REGS; i++) begin
      if (idx == ADDR_W'(i)) v = regs[i*DATA_W +: DATA_W];
    end
    return v;
  endfunction

  function automatic logic [DATA_W-1:0] sel_ro(input logic [ADDR_W-1:0] idx,
                                               input logic [RO_N*DATA_W-1:0] ro);
    logic [DATA_W-1:0] v;
    v = {DATA_W{1'b0}};
    for (int j = 0; j < NUM_RO; j++) begin
      if (idx == ADDR_W'(NUM_REGS + j)) v = ro[j*DATA_W +: DATA_W];
    end
    return v;
  endfunction

  w_state_t               r_wstate, w_wstate_nxt;
  r_state_t               r_rstate, w_rstate_nxt;
  logic                   r_aw_held, r_w_held;
  logic [ADDR_W-1:0]      r_awaddr;
  logic [DATA_W-1:0]      r_wdata;
  logic [NB-1:0]          r_wstrb;
  logic [NUM_REGS*DATA_W-1:0] r_regs;
  logic [NUM_REGS-1:0]    r_wpulse;
  logic                   r_bvalid, r_rvalid;
  logic [1:0]             r_bresp, r_rresp;
  logic [DATA_W-1:0]      r_rdata;
  logic                   w_awready, w_wready, w_commit;
  logic                   w_arready, w_ar_fire;
  logic [DATA_W-1:0]      w_rd_data;
  logic [1:0]             w_rd_resp;
  logic [ADDR_W-1:0]      w_wr_idx, w_rd_idx;
  logic                   w_wr_rw;

  assign w_wr_idx = addr_idx(r_awaddr);
  assign w_wr_rw  = is_rw(r_awaddr);
  assign w_rd_idx = addr_idx(s.araddr);

  // Write FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_wstate <= W_IDLE;
    else     r_wstate <= w_wstate_nxt;
  end

  // Write FSM next state, channel readies and the commit strobe.
  always_comb begin
    w_wstate_nxt = r_wstate;
    w_awready    = 1'b0;
    w_wready     = 1'b0;
    w_commit     = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        w_awready = !r_aw_held;
        w_wready  = !r_w_held;
        if (r_aw_held && r_w_held) begin
          w_commit     = 1'b1;
          w_wstate_nxt = W_RESP;
        end else begin
          w_wstate_nxt = W_IDLE;
        end
      end
      W_RESP: begin
        if (s.bready) w_wstate_nxt = W_IDLE;
        else          w_wstate_nxt = W_RESP;
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  // Capture AW and W independently; both are released by the commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_awaddr  <= {ADDR_W{1'b0}};
      r_wdata   <= {DATA_W{1'b0}};
      r_wstrb   <= {NB{1'b0}};
    end else begin
      if (w_commit) begin
        r_aw_held <= 1'b0;
      end else if (s.awvalid && w_awready) begin
        r_aw_held <= 1'b1;
        r_awaddr  <= s.awaddr;
      end
      if (w_commit) begin
        r_w_held <= 1'b0;
      end else if (s.wvalid && w_wready) begin
        r_w_held <= 1'b1;
        r_wdata  <= s.wdata;
        r_wstrb  <= s.wstrb;
      end
    end
  end

  // Register update, write pulse and write response.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_regs   <= RW_RESET;
      r_wpulse <= {NUM_REGS{1'b0}};
      r_bvalid <= 1'b0;
      r_bresp  <= 2'b00;
    end else begin
      r_wpulse <= {NUM_REGS{1'b0}};
      if (w_commit) begin
        r_bvalid <= 1'b1;
        if (w_wr_rw) begin
          r_bresp <= 2'b00;
          for (int i = 0; i < NUM_REGS; i++) begin
            if (w_wr_idx == ADDR_W'(i)) begin
              r_wpulse[i] <= 1'b1;
              for (int b = 0; b < NB; b++) begin
                if (r_wstrb[b]) r_regs[i*DATA_W + b*8 +: 8] <= r_wdata[b*8 +: 8];
              end
            end
          end
        end else begin
          r_bresp <= 2'b10;
        end
      end else if ((r_wstate == W_RESP) && s.bready) begin
        r_bvalid <= 1'b0;
      end
    end
  end

  // Read FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_rstate <= R_IDLE;
    else     r_rstate <= w_rstate_nxt;
  end

  // Read FSM next state and address handshake.
  always_comb begin
    w_rstate_nxt = r_rstate;
    w_arready    = 1'b0;
    w_ar_fire    = 1'b0;
    case (r_rstate)
      R_IDLE: begin
        w_arready = 1'b1;
        if (s.arvalid) begin
          w_ar_fire    = 1'b1;
          w_rstate_nxt = R_DATA;
        end else begin
          w_rstate_nxt = R_IDLE;
        end
      end
      R_DATA: begin
        if (s.rready) w_rstate_nxt = R_IDLE;
        else          w_rstate_nxt = R_DATA;
      end
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  // Read data mux; reads see register contents from before any same-edge commit.
  always_comb begin
    w_rd_data = {DATA_W{1'b0}};
    w_rd_resp = 2'b10;
    if (is_rw(s.araddr)) begin
      w_rd_data = sel_rw(w_rd_idx, r_regs);
      w_rd_resp = 2'b00;
    end else if (is_ro(s.araddr)) begin
      w_rd_data = sel_ro(w_rd_idx, ro_status);
      w_rd_resp = 2'b00;
    end else begin
      w_rd_data = {DATA_W{1'b0}};
      w_rd_resp = 2'b10;
    end
  end

  // Read response registers, held until the master accepts them.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rvalid <= 1'b0;
      r_rdata  <= {DATA_W{1'b0}};
      r_rresp  <= 2'b00;
    end else if (w_ar_fire) begin
      r_rvalid <= 1'b1;
      r_rdata  <= w_rd_data;
      r_rresp  <= w_rd_resp;
    end else if ((r_rstate == R_DATA) && s.rready) begin
      r_rvalid <= 1'b0;
    end
  end

  assign s.awready  = w_awready;
  assign s.wready   = w_wready;
  assign s.bvalid   = r_bvalid;
  assign s.bresp    = r_bresp;
  assign s.arready  = w_arready;
  assign s.rvalid   = r_rvalid;
  assign s.rdata    = r_rdata;
  assign s.rresp    = r_rresp;
  assign regs_q     = r_regs;
  assign reg_wpulse = r_wpulse;
endmodule
